// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// lane masks and alignment rules.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } lsu_size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

    function automatic logic [63:0] size_mask(input lsu_size_t size);
        case (size)
            BYTE:    size_mask = 64'h0000_0000_0000_00FF;
            HALF:    size_mask = 64'h0000_0000_0000_FFFF;
            WORD:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic misaligned(input lsu_size_t size, input logic [2:0] off);
        case (size)
            BYTE:    misaligned = 1'b0;
            HALF:    misaligned = off[0];
            WORD:    misaligned = |off[1:0];
            default: misaligned = |off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane datapath: extracts and extends load data from a memory
// doubleword, and merges store data into the previously read doubleword.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_size_t   i_size,
    input  logic        i_unsigned,
    input  logic [2:0]  i_off,
    input  logic [63:0] i_mem_rd,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_old,
    output logic [63:0] o_load_val,
    output logic [63:0] o_store_val
);

    logic [5:0]  w_shamt;
    logic [63:0] w_mask;
    logic [63:0] w_field;
    logic [63:0] w_lmask;

    assign w_shamt = {i_off, 3'b000};
    assign w_mask  = size_mask(i_size);
    assign w_field = (i_mem_rd >> w_shamt) & w_mask;
    assign w_lmask = w_mask << w_shamt;

    always_comb begin
        // NOTE: default first so every path assigns o_load_val and no latch is inferred.
        o_load_val = w_field;
        if (!i_unsigned) begin
            case (i_size)
                BYTE:    o_load_val = {{56{w_field[7]}},  w_field[7:0]};
                HALF:    o_load_val = {{48{w_field[15]}}, w_field[15:0]};
                WORD:    o_load_val = {{32{w_field[31]}}, w_field[31:0]};
                default: o_load_val = w_field;
            endcase
        end
    end

    assign o_store_val = (i_size == DWORD) ? i_wdata
                       : (i_old & ~w_lmask) | ((i_wdata << w_shamt) & w_lmask);

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit in front of a combinational-read data memory;
// one request at a time, read-modify-write for sub-doubleword stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd
);

    lsu_state_t      r_state;
    lsu_state_t      w_next;
    logic            r_we;
    lsu_size_t       r_size;
    logic            r_unsigned;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rd_buf;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    lsu_size_t       w_req_size;
    logic            w_accept;
    logic            w_misaligned;
    logic [XLEN-1:0] w_load_val;
    logic [XLEN-1:0] w_store_val;

    assign w_req_size   = lsu_size_t'(req_size);
    assign w_accept     = req_valid && req_ready;
    assign w_misaligned = misaligned(w_req_size, req_addr[2:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Handshake and write strobe decode from state alone, so reset drops them at once.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_we    = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_misaligned)            w_next = RESP;
                    else if (!req_we)            w_next = LOAD;
                    else if (w_req_size == DWORD) w_next = WRITE;
                    else                         w_next = READ;
                end
            end
            READ:    w_next = WRITE;
            LOAD:    w_next = RESP;
            WRITE: begin
                mem_we = 1'b1;
                w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_buf   <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_size     <= w_req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        if (w_misaligned) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                READ: r_rd_buf <= mem_rd;
                LOAD: begin
                    r_rdata <= w_load_val;
                    r_err   <= 1'b0;
                end
                WRITE: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    lsu_lane_align u_lane_align (
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_off       (r_addr[2:0]),
        .i_mem_rd    (mem_rd),
        .i_wdata     (r_wdata),
        .i_old       (r_rd_buf),
        .o_load_val  (w_load_val),
        .o_store_val (w_store_val)
    );

    assign mem_addr  = {1'b0, r_addr[XLEN-1:3], 2'b00};
    assign mem_wd    = (r_state == WRITE) ? w_store_val : '0;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // r_we is kept for the request record; the FSM has already routed on it.
    logic w_unused;
    assign w_unused = r_we;

endmodule
